// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: latches one request at a time and runs it through
// a fixed IDLE -> ACCESS -> RESP sequence against the single memory port.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        port_q;
  logic        last_grant_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic grant_valid;
  logic grant_port;
  logic is_read;

  assign is_read = (wmask_q == 4'b0000);

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    mem_rstrb   = 1'b0;
    mem_wmask   = 4'b0000;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    owner       = 2'b00;
    m0_rdata    = rdata0_q;
    m1_rdata    = rdata1_q;
    case (state_q)
      IDLE: begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
          grant_port = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
          grant_port = m1_req;
        end
        if (grant_valid) state_d = ACCESS;
      end
      ACCESS: begin
        owner   = port_q ? 2'b10 : 2'b01;
        state_d = RESP;
        if (is_read) mem_rstrb = 1'b1;
        else         mem_wmask = wmask_q;
      end
      RESP: begin
        owner   = port_q ? 2'b10 : 2'b01;
        state_d = IDLE;
        m0_ack  = ~port_q;
        m1_ack  = port_q;
        // Read data bypasses the register so it is already valid in the ack cycle.
        if (is_read && !port_q) m0_rdata = mem_rdata;
        if (is_read &&  port_q) m1_rdata = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        port_q       <= grant_port;
        last_grant_q <= grant_port;
        addr_q       <= grant_port ? m1_addr  : m0_addr;
        wdata_q      <= grant_port ? m1_wdata : m0_wdata;
        wmask_q      <= grant_port ? m1_wmask : m0_wmask;
      end
      if (state_q == RESP && is_read) begin
        if (port_q) rdata1_q <= mem_rdata;
        else        rdata0_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a behavioural
// memory, plus a fixed-priority instance for the contention case.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  owner;

  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_m0_ack, fp_m1_ack, fp_mem_rstrb;
  logic [3:0]  fp_mem_wmask;
  logic [1:0]  fp_owner;
  logic [31:0] fp_mem_rdata = '0;

  logic [31:0] mem [0:63];
  int total = 0;
  int bad = 0;

  always #5 clk = clk_en ? ~clk : clk;

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rdata(fp_m0_rdata), .m0_ack(fp_m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rdata(fp_m1_rdata), .m1_ack(fp_m1_ack),
    .mem_addr(fp_mem_addr), .mem_rstrb(fp_mem_rstrb), .mem_wdata(fp_mem_wdata),
    .mem_wmask(fp_mem_wmask), .mem_rdata(fp_mem_rdata), .owner(fp_owner)
  );

  // Behavioural memory: registered read, byte-masked write on the clock edge.
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[32'h10 >> 2] = 32'hDEADBEEF;

    // Reset with no clock running
    #3 rst = 1'b1;
    #1;
    check("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
    check("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
    check("rst_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("rst_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst_owner", {30'b0, owner}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    #2 rst = 1'b0;
    clk_en = 1'b1;
    step();

    // Single read on port 0
    m0_req = 1'b1; m0_addr = 32'h10; m0_wmask = 4'b0000;
    check("rd_idle_owner", {30'b0, owner}, 32'd0);
    step();
    check("rd_acc_rstrb", {31'b0, mem_rstrb}, 32'd1);
    check("rd_acc_addr", mem_addr, 32'h10);
    check("rd_acc_owner", {30'b0, owner}, 32'd1);
    check("rd_acc_ack", {31'b0, m0_ack}, 32'd0);
    step();
    check("rd_resp_ack", {31'b0, m0_ack}, 32'd1);
    check("rd_resp_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("rd_resp_data", m0_rdata, 32'hDEADBEEF);
    m0_req = 1'b0;
    step();
    check("rd_idle_ack", {31'b0, m0_ack}, 32'd0);
    check("rd_idle_owner2", {30'b0, owner}, 32'd0);
    step();
    check("rd_hold_data", m0_rdata, 32'hDEADBEEF);

    // Byte write on port 1, then read back on port 0
    m1_req = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_wmask = 4'b0010;
    step();
    check("wr_acc_wmask", {28'b0, mem_wmask}, 32'h2);
    check("wr_acc_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("wr_acc_owner", {30'b0, owner}, 32'd2);
    step();
    check("wr_resp_wmask", {28'b0, mem_wmask}, 32'd0);
    check("wr_resp_ack", {31'b0, m1_ack}, 32'd1);
    check("wr_resp_m0ack", {31'b0, m0_ack}, 32'd0);
    check("wr_resp_m1_rdata", m1_rdata, 32'd0);
    check("wr_mem", mem[32'h20 >> 2], 32'h00003300);
    m1_req = 1'b0;
    step();
    m0_req = 1'b1; m0_addr = 32'h20; m0_wmask = 4'b0000;
    step();
    step();
    check("rb_ack", {31'b0, m0_ack}, 32'd1);
    check("rb_data", m0_rdata, 32'h00003300);
    check("rb_m1_rdata", m1_rdata, 32'd0);
    m0_req = 1'b0;
    step();

    // Request fields change and req drops during ACCESS
    m0_req = 1'b1; m0_addr = 32'h10; m0_wmask = 4'b0000;
    step();
    m0_addr = 32'h3C; m0_req = 1'b0;
    check("stab_acc_addr", mem_addr, 32'h10);
    begin
      int acks = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (i == 0) check("stab_resp_addr", mem_addr, 32'h10);
        if (m0_ack) acks++;
      end
      check("stab_ack_count", acks, 32'd1);
    end
    check("stab_data", m0_rdata, 32'hDEADBEEF);

    // Reset in the middle of a write
    m1_req = 1'b1; m1_addr = 32'h30; m1_wdata = 32'hFFFFFFFF; m1_wmask = 4'b1111;
    step();
    check("rstw_acc_wmask", {28'b0, mem_wmask}, 32'hF);
    #2 rst = 1'b1;
    #1;
    check("rstw_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rstw_owner", {30'b0, owner}, 32'd0);
    check("rstw_mem_addr", mem_addr, 32'd0);
    check("rstw_m0_rdata", m0_rdata, 32'd0);
    m1_req = 1'b0;
    step();
    rst = 1'b0;
    begin
      int acks = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (m1_ack) acks++;
      end
      check("rstw_no_ack", acks, 32'd0);
    end
    check("rstw_mem", mem[32'h30 >> 2], 32'd0);

    // Contention from reset: both requesting reads
    m0_req = 1'b1; m0_addr = 32'h10; m0_wmask = 4'b0000;
    m1_req = 1'b1; m1_addr = 32'h20; m1_wmask = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("rr_m0_ack_%0d", i), {31'b0, m0_ack}, {31'b0, (i == 2 || i == 8)});
      check($sformatf("rr_m1_ack_%0d", i), {31'b0, m1_ack}, {31'b0, (i == 5 || i == 11)});
      check($sformatf("fp_m0_ack_%0d", i), {31'b0, fp_m0_ack}, {31'b0, (i % 3 == 2)});
      check($sformatf("fp_m1_ack_%0d", i), {31'b0, fp_m1_ack}, 32'd0);
      if (i == 5) check("rr_m1_data", m1_rdata, 32'h00003300);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
